// File: rtl/mem_port_arbiter.sv
// Shares the CpuMem block-RAM data port between the VGA fetch engine and the CPU.
// Grants one access per cycle and returns read data to its owner after READ_LATENCY cycles.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W         = 16,
   parameter int unsigned DATA_W         = 16,
   parameter int unsigned READ_LATENCY   = 1,
   parameter int unsigned MAX_VGA_STREAK = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              vga_req,
   input  logic [ADDR_W-1:0] vga_addr,
   output logic              vga_gnt,
   output logic              vga_rvalid,
   output logic [DATA_W-1:0] vga_rdata,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   localparam int unsigned   SW         = $clog2(MAX_VGA_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_VGA_STREAK);

   typedef enum logic [1:0] {GNT_NONE, GNT_VGA, GNT_CPU} grant_t;

   logic                    r_run;
   logic [SW-1:0]           r_streak;
   logic [READ_LATENCY-1:0] r_tag_vld;
   logic [READ_LATENCY-1:0] r_tag_cpu;
   logic [DATA_W-1:0]       r_vga_rdata;
   logic [DATA_W-1:0]       r_cpu_rdata;

   grant_t w_grant;
   logic   w_cpu_ok;
   logic   w_force_cpu;
   logic   w_tail_vld;
   logic   w_tail_cpu;

   assign w_cpu_ok    = r_run & cpu_req;
   assign w_force_cpu = w_cpu_ok & (r_streak == STREAK_MAX);

   // Grants are qualified by reset so the RAM port stays idle while reset is held.
   always_comb begin
      w_grant = GNT_NONE;
      if (reset) begin
         if (w_force_cpu || (w_cpu_ok && !vga_req)) begin
            w_grant = GNT_CPU;
         end else if (vga_req) begin
            w_grant = GNT_VGA;
         end
      end
   end

   always_comb begin
      vga_gnt   = 1'b0;
      cpu_gnt   = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (w_grant)
         GNT_VGA: begin
            vga_gnt  = 1'b1;
            mem_en   = 1'b1;
            mem_addr = vga_addr;
         end
         GNT_CPU: begin
            cpu_gnt   = 1'b1;
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
         end
         default: ;
      endcase
   end

   assign w_tail_vld = r_tag_vld[READ_LATENCY-1];
   assign w_tail_cpu = r_tag_cpu[READ_LATENCY-1];

   assign vga_rvalid = w_tail_vld & ~w_tail_cpu;
   assign cpu_rvalid = w_tail_vld &  w_tail_cpu;

   // Fresh RAM data is passed straight through on the return cycle; otherwise the last value holds.
   assign vga_rdata = vga_rvalid ? mem_rdata : r_vga_rdata;
   assign cpu_rdata = cpu_rvalid ? mem_rdata : r_cpu_rdata;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_run       <= 1'b0;
         r_streak    <= '0;
         r_tag_vld   <= '0;
         r_tag_cpu   <= '0;
         r_vga_rdata <= '0;
         r_cpu_rdata <= '0;
      end else begin
         if (start) begin
            r_run <= 1'b1;
         end

         if (!w_cpu_ok || w_grant == GNT_CPU) begin
            r_streak <= '0;
         end else if (w_grant == GNT_VGA && r_streak != STREAK_MAX) begin
            r_streak <= r_streak + SW'(1);
         end

         r_tag_vld[0] <= mem_en & ~mem_we;
         r_tag_cpu[0] <= (w_grant == GNT_CPU);
         for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            r_tag_vld[i] <= r_tag_vld[i-1];
            r_tag_cpu[i] <= r_tag_cpu[i-1];
         end

         if (vga_rvalid) begin
            r_vga_rdata <= mem_rdata;
         end
         if (cpu_rvalid) begin
            r_cpu_rdata <= mem_rdata;
         end
      end
   end

endmodule
